// File: rtl/mem_store_align_if.sv
// Store request, memory write and load-hazard signals of mem_store_align.
// slave: the aligner/write buffer; master: the pipeline and memory side.
interface mem_store_align_if;
    logic        StValid;
    logic        StReady;
    logic [31:0] StAddr;
    logic [31:0] StData;
    logic [3:0]  StMask;
    logic        StMisalign;
    logic        MemWReq;
    logic        MemWAck;
    logic [31:0] MemWAddr;
    logic [31:0] MemWData;
    logic [3:0]  MemWBE;
    logic [31:0] LdAddr;
    logic        LdHazard;
    logic        Empty;

    modport slave (
        input  StValid, StAddr, StData, StMask,
        input  MemWAck, LdAddr,
        output StReady, StMisalign,
        output MemWReq, MemWAddr, MemWData, MemWBE,
        output LdHazard, Empty
    );

    modport master (
        output StValid, StAddr, StData, StMask,
        output MemWAck, LdAddr,
        input  StReady, StMisalign,
        input  MemWReq, MemWAddr, MemWData, MemWBE,
        input  LdHazard, Empty
    );
endinterface

// File: rtl/mem_store_align.sv
// MEM-stage store aligner with an in-order write buffer drained over req/ack.
// Ports: clk, rst_n (async active-low), bus (mem_store_align_if.slave).
module mem_store_align #(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mem_store_align_if.slave        bus
);
    localparam int AW = $clog2(DEPTH);

    logic [29:0] r_addr  [DEPTH];
    logic [31:0] r_data  [DEPTH];
    logic [3:0]  r_be    [DEPTH];
    logic        r_valid [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_misalign;

    logic [1:0]  w_sub;
    logic [3:0]  w_be;
    logic [31:0] w_shift;
    logic [31:0] w_lane;
    logic        w_ill;
    logic        w_full;
    logic        w_empty;
    logic        w_acc;
    logic        w_push;
    logic        w_pop;
    logic        w_hit;
    logic        w_unused;

    assign w_unused = &{1'b0, bus.LdAddr[1:0]};

    assign w_sub   = bus.StAddr[1:0];
    assign w_be    = bus.StMask << w_sub;
    assign w_shift = bus.StData << {w_sub, 3'b000};

    // Bytes outside the enables are forced to zero in the entry.
    always_comb begin
        w_lane = '0;
        for (int i = 0; i < 4; i++) begin
            if (w_be[i]) w_lane[8*i +: 8] = w_shift[8*i +: 8];
        end
    end

    always_comb begin
        w_ill = 1'b1;
        unique case (bus.StMask)
            4'b0001: w_ill = 1'b0;
            4'b0011: w_ill = w_sub[0];
            4'b1111: w_ill = (w_sub != 2'b00);
            default: w_ill = 1'b1;
        endcase
    end

    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    // No pass-through: a full buffer refuses even while popping.
    assign w_acc   = bus.StValid && !w_full;
    assign w_push  = w_acc && !w_ill;
    assign w_pop   = !w_empty && bus.MemWAck;

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && r_addr[i] == bus.LdAddr[31:2])
                w_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i]  <= '0;
                r_data[i]  <= '0;
                r_be[i]    <= '0;
                r_valid[i] <= 1'b0;
            end
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_acc && w_ill;
            if (w_pop) begin
                r_valid[r_rptr] <= 1'b0;
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push) begin
                r_addr[r_wptr]  <= bus.StAddr[31:2];
                r_data[r_wptr]  <= w_lane;
                r_be[r_wptr]    <= w_be;
                r_valid[r_wptr] <= 1'b1;
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_push && !w_pop)
                r_count <= r_count + (AW+1)'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - (AW+1)'(1);
        end
    end

    assign bus.StReady    = !w_full;
    assign bus.Empty      = w_empty;
    assign bus.StMisalign = r_misalign;
    assign bus.MemWReq    = !w_empty;
    assign bus.LdHazard   = w_hit;
    assign bus.MemWAddr   = w_empty ? '0 : {r_addr[r_rptr], 2'b00};
    assign bus.MemWData   = w_empty ? '0 : r_data[r_rptr];
    assign bus.MemWBE     = w_empty ? '0 : r_be[r_rptr];
endmodule

// File: tb/tb_mem_store_align.sv
// Randomized and directed bench for mem_store_align against a queue model.
// Inputs change on the falling edge; outputs are checked just after.
module tb_mem_store_align;
    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    ent_t q[$];
    logic exp_mis;

    mem_store_align_if bus ();

    mem_store_align #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(logic [3:0] m);
        if (m == 4'b0001) return 1;
        if (m == 4'b0011) return 2;
        if (m == 4'b1111) return 4;
        return 0;
    endfunction

    function automatic ent_t mk(logic [31:0] a, logic [31:0] d, int n);
        ent_t e;
        int   off;
        off    = int'(a % 4);
        e.addr = a - a % 4;
        e.data = '0;
        e.be   = '0;
        for (int k = 0; k < n; k++) begin
            e.data[8*(off+k) +: 8] = d[8*k +: 8];
            e.be[off+k] = 1'b1;
        end
        return e;
    endfunction

    task automatic check_outs(string tag);
        logic [31:0] ea, ed;
        logic [3:0]  eb;
        logic        hz;
        ea = 0; ed = 0; eb = 0; hz = 0;
        if (q.size() > 0) begin
            ea = q[0].addr; ed = q[0].data; eb = q[0].be;
        end
        foreach (q[i])
            if (q[i].addr[31:2] == bus.LdAddr[31:2]) hz = 1;
        chk({tag, ".rdy"}, 32'(bus.StReady), 32'(q.size() < DEPTH));
        chk({tag, ".emp"}, 32'(bus.Empty), 32'(q.size() == 0));
        chk({tag, ".req"}, 32'(bus.MemWReq), 32'(q.size() != 0));
        chk({tag, ".addr"}, bus.MemWAddr, ea);
        chk({tag, ".data"}, bus.MemWData, ed);
        chk({tag, ".be"}, 32'(bus.MemWBE), 32'(eb));
        chk({tag, ".mis"}, 32'(bus.StMisalign), 32'(exp_mis));
        chk({tag, ".hz"}, 32'(bus.LdHazard), 32'(hz));
    endtask

    task automatic cyc(string tag, logic v, logic [31:0] a,
                       logic [31:0] d, logic [3:0] m,
                       logic ack, logic [31:0] ld);
        int  n;
        bit  acc, pop, ok;
        @(negedge clk);
        bus.StValid = v; bus.StAddr = a; bus.StData = d;
        bus.StMask = m; bus.MemWAck = ack; bus.LdAddr = ld;
        #1;
        check_outs(tag);
        n   = nbytes(m);
        ok  = (n != 0) && (a % n == 0);
        acc = v && (q.size() < DEPTH);
        pop = ack && (q.size() > 0);
        exp_mis = acc && !ok;
        if (pop) void'(q.pop_front());
        if (acc && ok) q.push_back(mk(a, d, n));
    endtask

    task automatic idle(string tag, logic ack, logic [31:0] ld);
        cyc(tag, 1'b0, 32'h0, 32'h0, 4'h0, ack, ld);
    endtask

    task automatic hit_reset(string tag);
        @(negedge clk);
        bus.StValid = 1'b0; bus.MemWAck = 1'b0;
        rst_n = 1'b0;
        #1;
        q.delete();
        exp_mis = 1'b0;
        check_outs(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [3:0] masks [4];

    initial begin
        n_vec = 0; n_err = 0; exp_mis = 0;
        rst_n = 1'b0;
        bus.StValid = 0; bus.StAddr = 0; bus.StData = 0;
        bus.StMask = 0; bus.MemWAck = 0; bus.LdAddr = 0;
        #1;
        check_outs("rst");
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        cyc("byte", 1, 32'h1003, 32'h000000A5, 4'b0001, 0, 0);
        idle("byte1", 0, 0);
        chk("byte.d", bus.MemWData, 32'hA5000000);
        chk("byte.be", 32'(bus.MemWBE), 32'h8);
        idle("bdrain", 1, 0);

        cyc("half", 1, 32'h2002, 32'h0000BEEF, 4'b0011, 0, 0);
        idle("half1", 0, 0);
        chk("half.d", bus.MemWData, 32'hBEEF0000);
        chk("half.be", 32'(bus.MemWBE), 32'hC);
        idle("hdrain", 1, 0);
        idle("hidle", 0, 0);

        cyc("mis", 1, 32'h2001, 32'h0000BEEF, 4'b0011, 0, 0);
        idle("mis1", 0, 0);
        chk("mis.pulse", 32'(bus.StMisalign), 32'h1);
        chk("mis.emp", 32'(bus.Empty), 32'h1);
        idle("mis2", 0, 0);
        chk("mis.clr", 32'(bus.StMisalign), 32'h0);

        cyc("f0", 1, 32'h4000, 32'h11111111, 4'hF, 0, 0);
        cyc("f1", 1, 32'h4004, 32'h22222222, 4'hF, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc("hold", 1, 32'h4008, 32'h33333333, 4'hF, 0, 0);
        chk("full.rdy", 32'(bus.StReady), 32'h0);
        cyc("fpop", 1, 32'h4008, 32'h33333333, 4'hF, 1, 0);
        cyc("facc", 1, 32'h4008, 32'h33333333, 4'hF, 0, 0);
        idle("f2", 1, 0);
        idle("f3", 1, 0);
        idle("f4", 0, 0);

        cyc("hzw", 1, 32'h3000, 32'hCAFEF00D, 4'hF, 0, 32'h3000);
        idle("hz1", 0, 32'h3002);
        chk("hz.on", 32'(bus.LdHazard), 32'h1);
        idle("hz2", 0, 32'h3004);
        chk("hz.off", 32'(bus.LdHazard), 32'h0);
        idle("hz3", 1, 32'h3002);
        idle("hz4", 0, 32'h3002);
        chk("hz.drn", 32'(bus.LdHazard), 32'h0);

        cyc("r0", 1, 32'h5000, 32'h1, 4'hF, 0, 0);
        cyc("r1", 1, 32'h5004, 32'h2, 4'hF, 0, 0);
        idle("r2", 0, 0);
        hit_reset("midrst");
        chk("midrst.req", 32'(bus.MemWReq), 32'h0);

        masks[0] = 4'b0001; masks[1] = 4'b0011;
        masks[2] = 4'b1111; masks[3] = 4'b0000;
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] m;
            if ($urandom_range(0, 15) == 0)
                m = 4'($urandom);
            else
                m = masks[$urandom_range(0, 2)];
            cyc("rnd", 1'($urandom_range(0, 2) != 0),
                32'h3000 + $urandom_range(0, 23), $urandom, m,
                1'($urandom_range(0, 1)),
                32'h3000 + $urandom_range(0, 23));
            if (i == 700) hit_reset("rndrst");
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_store_align.md
# mem_store_align

Store-side companion to the load extractor in the MEM stage: accepts right-aligned store data with a size mask and byte address, and shifts it into its word lane with byte enables. It also rejects misaligned stores. Accepted stores are held in a small in-order write buffer and drained to word-wide data memory over a req/ack handshake. A combinational hazard flag lets the pipeline stall loads that hit a pending buffered store.

## Interface
- DEPTH, 2, write-buffer entries; power of two, >= 2
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- StValid  in  1  store request valid
- StReady  out  1  buffer can accept; equals !full (registered state only)
- StAddr  in  32  byte address of store
- StData  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- StMask  in  4  size mask: 4'b0001 byte, 4'b0011 half, 4'b1111 word; other values illegal
- StMisalign  out  1  registered one-cycle pulse: last accepted request was misaligned/illegal and dropped
- MemWReq  out  1  head entry valid toward memory
- MemWAck  in  1  memory accepted head entry this cycle
- MemWAddr  out  32  word address of head, bits [1:0] = 0
- MemWData  out  32  lane-aligned data of head
- MemWBE  out  4  byte enables of head
- LdAddr  in  32  address of load currently in MEM
- LdHazard  out  1  combinational: some valid entry has MemWAddr[31:2] == LdAddr[31:2]
- Empty  out  1  no valid entries

## Operation
- Handshake: transfer when StValid && StReady at a rising edge; StValid without StReady is held by the producer, no state change.
- Lane alignment on accept: sub = StAddr[1:0]; BE = StMask << sub (4 bits, truncated); data = StData << (8*sub); bytes outside BE stored as 0; entry address = {StAddr[31:2], 2'b00}.
- Misalignment/illegal:
  - StMask 4'b0011 with sub[0] = 1.
  - StMask 4'b1111 with sub != 0.
  - StMask not in {0001, 0011, 1111}.
  - Such a transfer is consumed (handshake completes) but not enqueued; StMisalign = 1 for exactly the following cycle.
- FIFO: write pointer, read pointer, count of log2(DEPTH)+1 bits; pointers wrap modulo DEPTH. Strict in-order drain; no merging or coalescing.
- Drain: MemWReq = !Empty; MemWAddr/MemWData/MemWBE driven from head entry and held stable while MemWReq && !MemWAck. On MemWReq && MemWAck, head pops at that edge.
- MemWAck while MemWReq = 0 is ignored.
- Simultaneous accept and pop: allowed when not full; count unchanged, both pointers advance. When full, StReady = 0 even if MemWAck is high that cycle (no pass-through).
- LdHazard compares only valid entries, all of them, independent of BE overlap; 0 when Empty.
- Empty outputs: MemWAddr/MemWData/MemWBE = 0 when Empty (not stale head).

## Timing
- Reset (async assert, sync-safe deassert by system): count/pointers 0, entries cleared. Outputs: StReady 1, Empty 1, MemWReq 0, MemWAddr 0, MemWData 0, MemWBE 0, StMisalign 0, LdHazard 0.
- Reset mid-operation discards all buffered stores, including one with MemWReq high and not yet acked.
- Latency: store accepted at edge N into an empty buffer gives MemWReq = 1 in cycle after N (one cycle).
- Throughput: one store per cycle while not full; sustained one drain per cycle when MemWAck held high.
- StMisalign asserts in the cycle after the accepting edge and clears the next cycle unless another illegal store is accepted.
- LdHazard reflects registered buffer contents plus current LdAddr, with no added delay. A store accepted at the same edge is visible from the next cycle.

## Test plan
- Byte store StAddr=0x1003, StData=0x000000A5, StMask=0001 -> entry MemWAddr=0x1000, MemWData=0xA5000000, MemWBE=1000, MemWReq high one cycle after accept.
- Half store StAddr=0x2002, StData=0x0000BEEF, StMask=0011 -> MemWData=0xBEEF0000, MemWBE=1100. Same with StAddr=0x2001 -> no enqueue, StMisalign=1 one cycle, Empty stays 1.
- Fill DEPTH=2 with MemWAck=0: StReady drops after second accept. Third StValid held until MemWAck pops head. Outputs stable while unacked, order preserved.
- Full buffer, MemWAck=1 and StValid=1 same cycle -> pop only, count 2->1; next cycle accept proceeds.
- Pending word store to 0x3000; LdAddr=0x3002 -> LdHazard=1; LdAddr=0x3004 -> 0; after ack drains entry -> 0.
- Assert rst_n=0 with two entries and MemWReq=1 -> immediately MemWReq=0, Empty=1, StReady=1, MemWBE=0.
